// File: rtl/conv_fprop2_mul_arb_pkg.sv
// conv_fprop2_mul_arb_pkg: shared defaults, tag type and round-robin pointer helper
package conv_fprop2_mul_arb_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ID_W   = 2;

    typedef struct packed {
        logic                valid;
        logic [DEF_ID_W-1:0] id;
    } tag_t;

    function automatic int rr_inc(input int ptr, input int n);
        return (ptr >= n - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/conv_fprop2_rr_arb.sv
// conv_fprop2_rr_arb: combinational round-robin pick; CONV_FPROP2_MUL_ARB_PRIO0_EN gives requester 0 absolute priority
module conv_fprop2_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_winner
);

    logic            w_found;
    logic [ID_W-1:0] w_idx;

    // scan upward from the pointer, wrapping; the first requesting index wins
    always_comb begin
        w_found  = 1'b0;
        w_idx    = '0;
        o_winner = '0;
`ifdef CONV_FPROP2_MUL_ARB_PRIO0_EN
        w_found  = i_req[0];
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = ID_W'((int'(i_ptr) + k) % NUM_REQ);
            if (!w_found && i_req[w_idx]) begin
                w_found  = 1'b1;
                o_winner = w_idx;
            end
        end
    end

    assign o_grant = (i_en && w_found) ? (NUM_REQ'(1) << o_winner) : '0;

endmodule

// File: rtl/conv_fprop2_mul_arb.sv
// conv_fprop2_mul_arb: shares one pipelined multiplier among requesters; optional CONV_FPROP2_MUL_ARB_PRIO0_EN
module conv_fprop2_mul_arb
    import conv_fprop2_mul_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = DEF_ID_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MUL_LAT = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic                      mul_ce,
    output logic [DATA_W-1:0]         mul_din0,
    output logic [DATA_W-1:0]         mul_din1,
    input  logic [DATA_W-1:0]         mul_dout,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ID_W-1:0]           out_id,
    output logic [DATA_W-1:0]         out_data,
    output logic                      busy
);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_w_t;

    tag_w_t            r_pipe [MUL_LAT];
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   w_winner;
    logic              w_issue;
    logic [DATA_W-1:0] w_a [NUM_REQ];
    logic [DATA_W-1:0] w_b [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_ops
        assign w_a[i] = req_a[i*DATA_W +: DATA_W];
        assign w_b[i] = req_b[i*DATA_W +: DATA_W];
    end

    // a held result freezes the multiplier and the tag pipe together
    assign mul_ce  = ~(out_valid & ~out_ready);
    assign w_issue = |req_valid & mul_ce;

    conv_fprop2_rr_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .i_en    (mul_ce),
        .o_grant (req_ready),
        .o_winner(w_winner)
    );

    assign mul_din0  = w_a[w_winner];
    assign mul_din1  = w_b[w_winner];
    assign out_valid = r_pipe[MUL_LAT-1].valid;
    assign out_id    = r_pipe[MUL_LAT-1].id;
    assign out_data  = mul_dout;

    // advance the round-robin pointer past each granted requester
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_ptr <= '0;
`ifdef CONV_FPROP2_MUL_ARB_PRIO0_EN
        else if (w_issue && w_winner != '0)
`else
        else if (w_issue)
`endif
            r_ptr <= ID_W'(rr_inc(int'(w_winner), NUM_REQ));
    end

    // tag pipe shifts in lockstep with the multiplier registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < MUL_LAT; k++) r_pipe[k] <= '0;
        end else if (mul_ce) begin
            r_pipe[0] <= '{valid: w_issue, id: w_winner};
            for (int k = 1; k < MUL_LAT; k++) r_pipe[k] <= r_pipe[k-1];
        end
    end

    // busy while any tag is in flight
    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < MUL_LAT; k++) busy = busy | r_pipe[k].valid;
    end

endmodule

// File: tb/tb_conv_fprop2_mul_arb.sv
// tb_conv_fprop2_mul_arb: directed checks of arbitration, tag pipe, backpressure and reset
module tb_conv_fprop2_mul_arb;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic           mul_ce;
    logic [W-1:0]   mul_din0, mul_din1;
    logic [W-1:0]   mul_dout = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [IW-1:0]  out_id;
    logic [W-1:0]   out_data;
    logic           busy;
    int             checks = 0;
    int             failures = 0;
    int             e;

    conv_fprop2_mul_arb #(.NUM_REQ(N), .ID_W(IW), .DATA_W(W), .MUL_LAT(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_data(out_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // one-stage external multiplier, holding while ce is low
    always @(posedge clk) if (mul_ce) mul_dout <= mul_din0 * mul_din1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_id", 32'(out_id), 0);
        chk("rst_ce", 32'(mul_ce), 1);
        chk("rst_ready", 32'(req_ready), 0);
        #10 reset = 1'b0;

        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = 32'(i + 1);
            req_b[i*W +: W] = 32'd10;
        end
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            #1 chk("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
            tick();
            chk("rr_valid", 32'(out_valid), 1);
            chk("rr_id", 32'(out_id), 32'(k % 4));
            chk("rr_data", out_data, 32'((k % 4 + 1) * 10));
        end
        req_valid = '0;

        req_a[2*W +: W] = 32'd7;
        req_b[2*W +: W] = -32'sd3;
        req_valid = 4'b0100;
        #1 chk("single_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        chk("single_valid", 32'(out_valid), 1);
        chk("single_id", 32'(out_id), 2);
        chk("single_data", out_data, 32'hFFFF_FFEB);
        tick();
        chk("idle_valid", 32'(out_valid), 0);
        chk("idle_busy", 32'(busy), 0);

        out_ready = 1'b0;
        req_a[1*W +: W] = 32'd5;
        req_b[1*W +: W] = 32'd6;
        req_valid = 4'b0010;
        #1 chk("bp_ready", 32'(req_ready), 32'b0010);
        tick();
        req_a[3*W +: W] = 32'h7FFF_FFFF;
        req_b[3*W +: W] = 32'd2;
        req_valid = 4'b1000;
        #1;
        chk("bp_ce", 32'(mul_ce), 0);
        chk("bp_noready", 32'(req_ready), 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_hold_valid", 32'(out_valid), 1);
            chk("bp_hold_id", 32'(out_id), 1);
            chk("bp_hold_data", out_data, 32'd30);
            chk("bp_hold_ce", 32'(mul_ce), 0);
            chk("bp_hold_ready", 32'(req_ready), 0);
        end
        out_ready = 1'b1;
        #1;
        chk("pop_ce", 32'(mul_ce), 1);
        chk("pop_ready", 32'(req_ready), 32'b1000);
        tick();
        req_valid = '0;
        chk("ovf_id", 32'(out_id), 3);
        chk("ovf_data", out_data, 32'hFFFF_FFFE);
        tick();

        out_ready = 1'b0;
        req_a[0*W +: W] = 32'd3;
        req_b[0*W +: W] = 32'd3;
        req_valid = 4'b0001;
        #1 chk("pre_rst_ready", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        chk("pre_rst_valid", 32'(out_valid), 1);
        chk("pre_rst_busy", 32'(busy), 1);
        chk("pre_rst_data", out_data, 32'd9);
        reset = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_id", 32'(out_id), 0);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        req_valid = 4'b0011;
        #1 chk("post_rst_ready", 32'(req_ready), 32'b0001);
        tick();
        chk("post_rst_id", 32'(out_id), 0);
        chk("post_rst_data", out_data, 32'd9);

        req_valid = 4'b1001;
        for (int k = 0; k < 4; k++) begin
`ifdef CONV_FPROP2_MUL_ARB_PRIO0_EN
            e = 0;
`else
            e = (k % 2 == 0) ? 3 : 0;
`endif
            #1 chk("mix_ready", 32'(req_ready), 32'(1 << e));
            tick();
            chk("mix_id", 32'(out_id), 32'(e));
            chk("mix_data", out_data, (e == 0) ? 32'd9 : 32'hFFFF_FFFE);
        end
        req_valid = 4'b1000;
        #1 chk("drop0_ready", 32'(req_ready), 32'b1000);
        tick();
        req_valid = '0;
        chk("drop0_id", 32'(out_id), 3);
        tick();
        chk("end_busy", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_fprop2_mul_arb.md
Name: conv_fprop2_mul_arb

Overview:
- Shares one pipelined signed 32x32->32 multiplier among NUM_REQ requesters in the conv_fprop2 datapath.
- Each requester presents operand pairs with a valid/ready handshake. A round-robin arbiter picks one per cycle and drives the multiplier's ce/din0/din1.
- Tags travel through a valid/ID pipeline matched to the multiplier latency. Results return on a single tagged output channel with backpressure.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, requester ID width; must be >= clog2(NUM_REQ)
- DATA_W, 32, operand and result width
- MUL_LAT, 1, multiplier register stages between din and dout (>=1)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester accept
- req_a  in  NUM_REQ*DATA_W  packed din0 operands; requester i at bits [i*DATA_W +: DATA_W]
- req_b  in  NUM_REQ*DATA_W  packed din1 operands
- mul_ce  out  1  multiplier clock enable
- mul_din0  out  DATA_W  operand A to multiplier
- mul_din1  out  DATA_W  operand B to multiplier
- mul_dout  in  DATA_W  multiplier result
- out_valid  out  1  result valid
- out_ready  in  1  result consumer accept
- out_id  out  ID_W  requester that owns out_data
- out_data  out  DATA_W  product, equal to mul_dout
- busy  out  1  any valid bit set in the tag pipeline

Behaviour:
- Reset: all tag-pipe valid bits = 0, rr pointer = 0, out_valid = 0, out_id = 0, busy = 0. In-flight products are dropped with no replay.
- Stall: stall = out_valid & ~out_ready; mul_ce = ~stall (combinational).
- Tag pipe: MUL_LAT stages of {valid, id}, shifted only when mul_ce = 1.
  - Stage 0 loads {issue, winner}.
  - out_valid and out_id come from the last stage.
  - This keeps the tag aligned with the multiplier's buff registers, which hold while ce = 0.
- Arbitration (combinational):
  - Search req_valid from rr pointer upward, wrapping modulo NUM_REQ; first set bit wins.
  - issue = |req_valid & mul_ce.
  - req_ready is one-hot(winner) when issue is set, else all 0. Only one requester is ever ready per cycle.
- Operand mux: mul_din0/din1 = operands of the winner. When there is no winner they hold the requester-0 operands, which are don't-care because stage-0 valid = 0.
- Pointer: on issue, pointer <= winner+1 mod NUM_REQ. On no issue, pointer holds.
- Throughput: 1 result/cycle with no stall. Latency is req handshake to out_valid = MUL_LAT cycles.
- Handshake rules:
  - A requester must hold req_valid/a/b stable until req_ready.
  - The result is transferred on out_valid & out_ready.
  - out_data/out_id stay stable while stalled.
- Simultaneous events:
  - A result pop and a new issue can occur in the same cycle (no stall when out_ready = 1).
  - While stalled, no issue occurs even if a requester is valid.
- Arithmetic: the product is two's-complement and truncated to DATA_W by the multiplier. This block never alters data.
- Wrap-around:
  - Pointer at NUM_REQ-1 wraps to 0.
  - When NUM_REQ is not a power of two, pointer values >= NUM_REQ are unreachable.

Optional Feature:
- Macro: CONV_FPROP2_MUL_ARB_PRIO0_EN.
- Defined: requester 0 has fixed absolute priority; whenever req_valid[0] = 1 and mul_ce = 1, it wins. The rr pointer updates only on grants to requesters 1..NUM_REQ-1, which share round-robin among themselves.
- Undefined: pure round-robin across all requesters.

Decomposition:
- Package conv_fprop2_mul_arb_pkg holds DATA_W/ID_W defaults, the tag struct typedef {logic valid; logic [ID_W-1:0] id;}, and a function for rr pointer increment mod NUM_REQ.
- Sub-module conv_fprop2_rr_arb holds the combinational round-robin pick (req vector, pointer, enable -> one-hot grant, winner index).
- The top holds the tag pipe, stall logic and operand mux.

Test Plan:
- Single requester: req 2 sends a=7, b=-3, out_ready=1.
  - Expected: out_valid one cycle later (MUL_LAT=1), out_id=2, out_data=-21.
- All four valid continuously, out_ready=1.
  - Expected: grants 0,1,2,3,0,...; one result per cycle; out_id follows the same order.
- Backpressure: out_ready=0 for 3 cycles while a result is pending.
  - Expected: mul_ce=0, req_ready=0, out_data/out_id held.
  - Then out_ready=1: the result pops and issue resumes the same cycle.
- Overflow operand: a=0x7FFFFFFF, b=2.
  - Expected: out_data=0xFFFFFFFE.
- Reset asserted with 1 result in flight and out stalled.
  - Expected: out_valid=0, busy=0, pointer=0 immediately (async).
  - Next grant after release goes to the lowest valid requester.
- PRIO0_EN defined, req0 and req3 valid every cycle.
  - Expected: req0 granted every cycle, req3 starves.
  - When req0 drops, req3 is granted.
